store_merge_unit: RTL

- Write-side counterpart of the load-path extension logic in the single-cycle/multi-cycle MIPS datapath.
- Takes a store request (sb/sh/sw) with a 32-bit register value and a byte address.
- Narrows the value to the requested size and merges it into a 32-bit-word data memory that has no byte enables. Byte and halfword stores use a read-modify-write sequence; word stores write directly.

---
 rtl/store_merge_if.sv | 28 ++
 rtl/store_merge_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/store_merge_if.sv
// Store request bus plus the port to a word-wide data memory with no byte enables.
// The store unit takes the slave side. The requester and the memory take the master side.
interface store_merge_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rdata,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rdata,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done, err
    );
endinterface

// File: rtl/store_merge_unit.sv
// Narrows sb/sh/sw store data and merges it into a word-only data memory.
// Sub-word stores use a read-modify-write sequence. Word stores write directly.
module store_merge_unit #(
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    store_merge_if.slave     bus
);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, ERR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        off_reg;
    logic [15:0]       lane_data_reg;
    logic              is_byte_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       merged;
    logic              accept;
    logic              misaligned;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

    assign accept = bus.req_valid && (state_reg == IDLE);

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = bus.req_addr[0];
            SZ_WORD: misaligned = (bus.req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (misaligned)                  state_next = ERR;
                    else if (bus.req_size == SZ_WORD) state_next = WR;
                    else                              state_next = RD;
                end
            end
            RD:      state_next = MERGE;
            MERGE:   state_next = WR;
            WR:      state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A lane is replaced when it matches the byte offset, or for a half when it is in the addressed half.
    // Odd lanes of a half take the upper byte of the store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;
            assign hit = is_byte_reg ? (off_reg == LANE) : (off_reg[1] == LANE[1]);
            assign src = (is_byte_reg || !LANE[0]) ? lane_data_reg[7:0] : lane_data_reg[15:8];
            assign merged[8*gi +: 8] = hit ? src : bus.mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            off_reg       <= 2'b00;
            lane_data_reg <= 16'h0000;
            is_byte_reg   <= 1'b0;
            wdata_reg     <= 32'h0000_0000;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addr_reg      <= bus.req_addr[ADDR_W+1:2];
                off_reg       <= bus.req_addr[1:0];
                lane_data_reg <= bus.req_data[15:0];
                is_byte_reg   <= (bus.req_size == SZ_BYTE);
                if (bus.req_size == SZ_WORD && !misaligned)
                    wdata_reg <= bus.req_data;
            end
            if (state_reg == MERGE)
                wdata_reg <= merged;
        end
    end

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.mem_rd_en = (state_reg == RD);
    assign bus.mem_wr_en = (state_reg == WR);
    assign bus.done      = (state_reg == WR) || (state_reg == ERR);
    assign bus.err       = (state_reg == ERR);
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
endmodule
